instruction_sequencer: RTL and testbench

//  Parametrised program-store sequencer: holds DEPTH instructions of WIDTH bits
//  and presents them one at a time to the downstream ALU over a valid/ready handshake.

---
 rtl/instruction_sequencer.sv | 133 +++++++++++++
 tb/tb_instruction_sequencer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/instruction_sequencer.sv
// Program-store sequencer: DEPTH x WIDTH instruction memory with a load port.
// Presents instructions one at a time to the ALU over valid/ready, with jump, wrap and done.
module instruction_sequencer #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 5,
    parameter int ADDR_W = 3,
    parameter int WRAP   = 0
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              start,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_addr,
    input  logic              ready,
    output logic [WIDTH-1:0]  instruction,
    output logic              valid,
    output logic [ADDR_W-1:0] pc,
    output logic              done,
    output logic              jump_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_PC   = ADDR_W'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  instr_q, instr_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              jump_err_q, jump_err_d;
    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [WIDTH-1:0]  mem_d [DEPTH];

    logic              wr_ok;
    logic              jump_ok;
    logic              fetch;
    logic [ADDR_W-1:0] fetch_addr;

    assign wr_ok   = wr_en && ({1'b0, wr_addr} < DEPTH_EXT);
    assign jump_ok = {1'b0, jump_addr} < DEPTH_EXT;

    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (wr_ok) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    // Fetch reads mem_q, so a same-cycle write to the fetched slot yields the old word.
    always_comb begin
        state_d    = state_q;
        instr_d    = instr_q;
        pc_d       = pc_q;
        jump_err_d = 1'b0;
        fetch      = 1'b0;
        fetch_addr = '0;

        case (state_q)
            IDLE, FIN: begin
                if (start) begin
                    state_d    = RUN;
                    fetch      = 1'b1;
                    fetch_addr = '0;
                end
            end
            RUN: begin
                if (start) begin
                    fetch      = 1'b1;
                    fetch_addr = '0;
                end else if (ready) begin
                    if (jump_en && jump_ok) begin
                        fetch      = 1'b1;
                        fetch_addr = jump_addr;
                    end else begin
                        jump_err_d = jump_en;
                        if (pc_q < LAST_PC) begin
                            fetch      = 1'b1;
                            fetch_addr = pc_q + ADDR_W'(1);
                        end else if (WRAP != 0) begin
                            fetch      = 1'b1;
                            fetch_addr = '0;
                        end else begin
                            state_d = FIN;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (fetch) begin
            instr_d = mem_q[fetch_addr];
            pc_d    = fetch_addr;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            instr_q    <= '0;
            pc_q       <= '0;
            jump_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            jump_err_q <= jump_err_d;
        end
    end

    // Program memory is deliberately left out of reset.
    always_ff @(posedge CLK) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
        end
    end

    assign instruction = instr_q;
    assign pc          = pc_q;
    assign valid       = (state_q == RUN);
    assign done        = (state_q == FIN);
    assign jump_err    = jump_err_q;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed bench for instruction_sequencer: one stop-at-end instance and one wrapping instance
// share all inputs; expected values are hand-computed per step.
module tb_instruction_sequencer;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic       start;
    logic       jump_en;
    logic [2:0] jump_addr;
    logic       ready;

    logic [7:0] instruction, instruction_w;
    logic       valid, valid_w;
    logic [2:0] pc, pc_w;
    logic       done, done_w;
    logic       jump_err, jump_err_w;

    int errors = 0;
    int checks = 0;

    logic [7:0] prog [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

    instruction_sequencer #(.WIDTH(8), .DEPTH(5), .ADDR_W(3), .WRAP(0)) dut (
        .CLK(CLK), .RST_N(RST_N), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .jump_en(jump_en), .jump_addr(jump_addr), .ready(ready),
        .instruction(instruction), .valid(valid), .pc(pc), .done(done), .jump_err(jump_err)
    );

    instruction_sequencer #(.WIDTH(8), .DEPTH(5), .ADDR_W(3), .WRAP(1)) dut_w (
        .CLK(CLK), .RST_N(RST_N), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .jump_en(jump_en), .jump_addr(jump_addr), .ready(ready),
        .instruction(instruction_w), .valid(valid_w), .pc(pc_w), .done(done_w),
        .jump_err(jump_err_w)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_main(input string tag, input logic [7:0] i, input logic [2:0] p,
                               input logic v, input logic d, input logic je);
        chk({tag, ".instr"}, 32'(instruction), 32'(i));
        chk({tag, ".pc"}, 32'(pc), 32'(p));
        chk({tag, ".valid"}, 32'(valid), 32'(v));
        chk({tag, ".done"}, 32'(done), 32'(d));
        chk({tag, ".jerr"}, 32'(jump_err), 32'(je));
    endtask

    initial begin
        RST_N = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; jump_en = 1'b0; jump_addr = '0; ready = 1'b0;
        tick();
        tick();
        expect_main("reset", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
        chk("reset_w.valid", 32'(valid_w), 32'd0);

        RST_N = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; wr_addr = 3'(i); wr_data = prog[i];
            tick();
        end
        wr_en = 1'b0;
        expect_main("idle_after_load", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);

        // T1 / T2: stream with ready=1
        start = 1'b1; ready = 1'b1;
        tick();
        start = 1'b0;
        expect_main("t1_c1", 8'h11, 3'd0, 1'b1, 1'b0, 1'b0);
        chk("t2_c1.instr", 32'(instruction_w), 32'h11);
        for (int k = 2; k <= 12; k++) begin
            tick();
            chk("t2.instr", 32'(instruction_w), 32'(prog[(k - 1) % 5]));
            chk("t2.pc", 32'(pc_w), 32'((k - 1) % 5));
            chk("t2.done", 32'(done_w), 32'd0);
            chk("t2.valid", 32'(valid_w), 32'd1);
            if (k <= 5) expect_main("t1_run", prog[k - 1], 3'(k - 1), 1'b1, 1'b0, 1'b0);
            else        expect_main("t1_done", 8'h55, 3'd4, 1'b0, 1'b1, 1'b0);
        end
        ready = 1'b0;

        // T3: back-pressure at slot 2
        start = 1'b1;
        tick();
        start = 1'b0;
        expect_main("t3_restart", 8'h11, 3'd0, 1'b1, 1'b0, 1'b0);
        ready = 1'b1;
        tick();
        tick();
        expect_main("t3_at2", 8'h33, 3'd2, 1'b1, 1'b0, 1'b0);
        ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            expect_main("t3_hold", 8'h33, 3'd2, 1'b1, 1'b0, 1'b0);
        end
        ready = 1'b1;
        tick();
        expect_main("t3_release", 8'h44, 3'd3, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        expect_main("t3_done", 8'h55, 3'd4, 1'b0, 1'b1, 1'b0);

        // T4: jumps
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        expect_main("t4_at1", 8'h22, 3'd1, 1'b1, 1'b0, 1'b0);
        jump_en = 1'b1; jump_addr = 3'd4;
        tick();
        expect_main("t4_jump4", 8'h55, 3'd4, 1'b1, 1'b0, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        expect_main("t4_start_prio", 8'h11, 3'd0, 1'b1, 1'b0, 1'b0);
        jump_en = 1'b0;
        tick();
        jump_en = 1'b1; jump_addr = 3'd7;
        tick();
        expect_main("t4_badjump", 8'h33, 3'd2, 1'b1, 1'b0, 1'b1);
        jump_en = 1'b0;
        tick();
        expect_main("t4_pulse_end", 8'h44, 3'd3, 1'b1, 1'b0, 1'b0);
        ready = 1'b0; jump_en = 1'b1; jump_addr = 3'd0;
        tick();
        expect_main("t4_jump_noacc", 8'h44, 3'd3, 1'b1, 1'b0, 1'b0);
        jump_en = 1'b0;

        // T5: write under a registered instruction
        start = 1'b1;
        tick();
        start = 1'b0; ready = 1'b1;
        tick();
        tick();
        expect_main("t5_at2", 8'h33, 3'd2, 1'b1, 1'b0, 1'b0);
        ready = 1'b0; wr_en = 1'b1; wr_addr = 3'd2; wr_data = 8'hAA;
        tick();
        expect_main("t5_out_stable", 8'h33, 3'd2, 1'b1, 1'b0, 1'b0);
        wr_addr = 3'd3;
        tick();
        wr_en = 1'b0; ready = 1'b1;
        tick();
        expect_main("t5_refetch", 8'hAA, 3'd3, 1'b1, 1'b0, 1'b0);
        wr_en = 1'b1; wr_addr = 3'd4; wr_data = 8'hBB;
        tick();
        wr_en = 1'b0;
        expect_main("t5_same_cycle_old", 8'h55, 3'd4, 1'b1, 1'b0, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0; jump_en = 1'b1; jump_addr = 3'd4;
        tick();
        jump_en = 1'b0;
        expect_main("t5_new_slot4", 8'hBB, 3'd4, 1'b1, 1'b0, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0; jump_en = 1'b1; jump_addr = 3'd2;
        tick();
        jump_en = 1'b0;
        expect_main("t5_slot2_rewritten", 8'hAA, 3'd2, 1'b1, 1'b0, 1'b0);

        // T6: reset mid-run
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        expect_main("t6_at2", 8'hAA, 3'd2, 1'b1, 1'b0, 1'b0);
        RST_N = 1'b0;
        tick();
        expect_main("t6_reset", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
        RST_N = 1'b1;
        tick();
        expect_main("t6_idle", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        expect_main("t6_resume", 8'h11, 3'd0, 1'b1, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
